// File: rtl/wb_cp0_exc.sv
// wb_cp0_exc: write-back stage with CP0 (STATUS/CAUSE/EPC/COUNT/COMPARE) and exception/eret redirect.
module wb_cp0_exc #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'd0,
  parameter int NUM_HW_INT = 6,
  parameter int COUNT_DIV = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_valid,
  input  logic [31:0]           wb_pc,
  input  logic                  wb_wen,
  input  logic [4:0]            wb_wdest,
  input  logic [31:0]           wb_result,
  input  logic [31:0]           wb_lo_result,
  input  logic                  hi_write,
  input  logic                  lo_write,
  input  logic                  mfhi,
  input  logic                  mflo,
  input  logic                  mfc0,
  input  logic                  mtc0,
  input  logic [7:0]            cp0r_addr,
  input  logic                  syscall,
  input  logic                  brk,
  input  logic                  eret,
  input  logic                  overflow,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [3:0]            rf_wen,
  output logic [4:0]            rf_wdest,
  output logic [31:0]           rf_wdata,
  output logic                  wb_over,
  output logic [4:0]            wb_wdest_o,
  output logic                  exc_valid,
  output logic [31:0]           exc_pc,
  output logic                  cancel,
  output logic                  timer_int,
  output logic [31:0]           hi_data,
  output logic [31:0]           lo_data
);
  localparam int DW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  localparam logic [7:0] A_COUNT = 8'h48, A_CMP = 8'h58, A_STATUS = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic [31:0] hi_q, hi_d, lo_q, lo_d, epc_q, epc_d, count_q, count_d, compare_q, compare_d;
  logic [7:0] im_q, im_d;
  logic exl_q, exl_d, ie_q, ie_d, ti_q, ti_d;
  logic [1:0] ipsw_q, ipsw_d;
  logic [4:0] code_q, code_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0] hw6;
  logic [7:0] ip;
  logic [4:0] code;
  logic [31:0] cp0_rdata;
  logic int_take, exc, eret_take, retire, tick;
  logic w_count, w_cmp, w_status, w_cause, w_epc;

  // Unused hardware lines zero-extend, so IP[7] only sees hw_int[5] when all six exist
  assign hw6       = 6'(hw_int);
  assign ip        = {ti_q | hw6[5], hw6[4:0], ipsw_q};
  assign int_take  = wb_valid & ie_q & ~exl_q & |(ip & im_q);
  assign exc       = wb_valid & (int_take | overflow | syscall | brk);
  assign code      = int_take ? 5'd0 : overflow ? 5'd12 : syscall ? 5'd8 : 5'd9;
  assign eret_take = wb_valid & eret & ~exc;
  assign retire    = wb_valid & ~exc;
  assign w_count   = retire & mtc0 & (cp0r_addr == A_COUNT);
  assign w_cmp     = retire & mtc0 & (cp0r_addr == A_CMP);
  assign w_status  = retire & mtc0 & (cp0r_addr == A_STATUS);
  assign w_cause   = retire & mtc0 & (cp0r_addr == A_CAUSE);
  assign w_epc     = retire & mtc0 & (cp0r_addr == A_EPC);
  assign tick      = div_q == DW'(COUNT_DIV - 1);

  assign cp0_rdata = cp0r_addr == A_COUNT  ? count_q :
                     cp0r_addr == A_CMP    ? compare_q :
                     cp0r_addr == A_STATUS ? {16'd0, im_q, 6'd0, exl_q, ie_q} :
                     cp0r_addr == A_CAUSE  ? {ti_q, 15'd0, ip, 1'b0, code_q, 2'd0} :
                     cp0r_addr == A_EPC    ? epc_q : 32'd0;

  assign rf_wen     = {4{retire & wb_wen}};
  assign rf_wdest   = wb_wdest;
  assign rf_wdata   = mfhi ? hi_q : mflo ? lo_q : mfc0 ? cp0_rdata : wb_result;
  assign wb_over    = wb_valid;
  assign wb_wdest_o = wb_wdest & {5{wb_valid}};
  assign exc_valid  = resetn & (exc | eret_take);
  assign cancel     = exc_valid;
  assign exc_pc     = exc ? EXC_ENTER_ADDR : epc_q;
  assign timer_int  = ti_q;
  assign hi_data    = hi_q;
  assign lo_data    = lo_q;

  always_comb begin
    hi_d      = retire & hi_write ? wb_result : hi_q;
    lo_d      = retire & lo_write ? wb_lo_result : lo_q;
    div_d     = w_count | tick ? '0 : div_q + 1'b1;
    count_d   = w_count ? wb_result : count_q + {31'd0, tick};
    compare_d = w_cmp ? wb_result : compare_q;
    ti_d      = w_cmp ? 1'b0 : ti_q | ((count_d == compare_d) & |compare_d);
    epc_d     = exc ? wb_pc : w_epc ? wb_result : epc_q;
    exl_d     = w_status ? wb_result[1] : exc ? 1'b1 : eret_take ? 1'b0 : exl_q;
    ie_d      = w_status ? wb_result[0] : ie_q;
    im_d      = w_status ? wb_result[15:8] : im_q;
    code_d    = exc ? code : code_q;
    ipsw_d    = w_cause ? wb_result[9:8] : ipsw_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0; lo_q <= '0; epc_q <= '0; count_q <= '0; compare_q <= '0;
      im_q <= '0; exl_q <= 1'b0; ie_q <= 1'b0; ti_q <= 1'b0;
      ipsw_q <= '0; code_q <= '0; div_q <= '0;
    end else begin
      hi_q <= hi_d; lo_q <= lo_d; epc_q <= epc_d; count_q <= count_d; compare_q <= compare_d;
      im_q <= im_d; exl_q <= exl_d; ie_q <= ie_d; ti_q <= ti_d;
      ipsw_q <= ipsw_d; code_q <= code_d; div_q <= div_d;
    end
  end
endmodule
